// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: produces per-stage enable/flush controls for
// load-use stalls, taken-branch flushes and multi-cycle data-memory freezes,
// and keeps a saturating count of stalled/frozen cycles.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 2,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             br_taken,
  output logic             pc_en,
  output logic             if2id_en,
  output logic             if2id_flush,
  output logic             id2ex_en,
  output logic             id2ex_flush,
  output logic             ex2mem_en,
  output logic             mem2wb_en,
  output logic             mem2wb_bubble,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DONE} state_t;

  // The first freeze cycle is spent in RUN, the last one in WAIT with cnt=0,
  // so WAIT is loaded with two fewer than the total freeze length.
  localparam int         WAIT_INIT_I = (MEM_WAIT >= 2) ? MEM_WAIT - 2 : 0;
  localparam logic [3:0] WAIT_INIT   = WAIT_INIT_I[3:0];
  localparam logic       HAS_WAIT    = (MEM_WAIT > 0);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic             acc;
  logic             freeze;
  logic             hazard;
  logic [1:0][4:0]  wr_dest;
  logic [1:0]       wr_en;
  logic [1:0]       wr_match;

  assign acc    = mem_r_en | mem_w_en;
  assign freeze = ((state_reg == ST_RUN) && acc && HAS_WAIT) || (state_reg == ST_WAIT);

  // Writer 0 is the instruction in EX, writer 1 the one in MEM. With
  // forwarding only a load in EX can stall; without it, any EX or MEM writer can.
  assign wr_dest[0] = ex_dest;
  assign wr_dest[1] = mem_dest;
  assign wr_en[0]   = ex_wb_en & ((FWD_EN != 0) ? ex_mem_r_en : 1'b1);
  assign wr_en[1]   = mem_wb_en & (FWD_EN == 0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_match
      assign wr_match[gi] = wr_en[gi] && (wr_dest[gi] != 5'd0) &&
                            ((wr_dest[gi] == id_src1) ||
                             (id_two_src && (wr_dest[gi] == id_src2)));
    end
  endgenerate

  assign hazard = |wr_match;

  // State, wait counter and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      cnt_reg       <= 4'd0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if ((freeze || hazard) && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  // Next-state logic for the memory-freeze sequencer.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (acc && (MEM_WAIT >= 2)) begin
          state_next = ST_WAIT;
          cnt_next   = WAIT_INIT;
        end else if (acc && (MEM_WAIT == 1)) begin
          state_next = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) state_next = ST_DONE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      // DONE lets the completed access advance once without retriggering.
      ST_DONE: state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  // Prioritised pipeline controls: reset, freeze, hazard, branch, normal.
  always_comb begin
    pc_en         = 1'b1;
    if2id_en      = 1'b1;
    if2id_flush   = 1'b0;
    id2ex_en      = 1'b1;
    id2ex_flush   = 1'b0;
    ex2mem_en     = 1'b1;
    mem2wb_en     = 1'b1;
    mem2wb_bubble = 1'b0;
    mem_busy      = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_en         = 1'b0;
        if2id_en      = 1'b0;
        id2ex_en      = 1'b0;
        ex2mem_en     = 1'b0;
        mem2wb_en     = 1'b0;
        mem2wb_bubble = 1'b1;
        mem_busy      = 1'b1;
      end else if (hazard) begin
        // Branch operands are not valid yet, so br_taken waits for the stall.
        pc_en       = 1'b0;
        if2id_en    = 1'b0;
        id2ex_flush = 1'b1;
      end else if (br_taken) begin
        if2id_flush = 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: five parameter variants share one stimulus and
// are compared every cycle against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_src1, id_src2, ex_dest, mem_dest;
  logic id_two_src, ex_wb_en, ex_mem_r_en, mem_wb_en, mem_r_en, mem_w_en, br_taken;

  // {pc_en, if2id_en, if2id_flush, id2ex_en, id2ex_flush, ex2mem_en, mem2wb_en, mem2wb_bubble, mem_busy}
  localparam logic [8:0] NORMAL = 9'b110101100;
  localparam logic [8:0] FREEZE = 9'b000000011;
  localparam logic [8:0] HAZARD = 9'b000111100;
  localparam logic [8:0] BRANCH = 9'b111101100;

  logic [4:0][8:0]  ctrl;
  logic [4:0][15:0] sc_dut;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // Reference model state: freeze cycles still owed, pending advance cycle, counts.
  int          forced [5];
  bit          skip   [5];
  logic [15:0] scnt   [5];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
      localparam int MW = (gi == 0) ? 3 : (gi == 1) ? 0 : (gi == 2) ? 1 : (gi == 3) ? 4 : 2;
      localparam int FW = (gi == 4) ? 0 : 1;
      localparam int CW = (gi == 4) ? 2 : 16;
      logic pc_en, if2id_en, if2id_flush, id2ex_en, id2ex_flush;
      logic ex2mem_en, mem2wb_en, mem2wb_bubble, mem_busy;
      logic [CW-1:0] stall_cnt;
      pipe_hazard_ctrl #(.MEM_WAIT(MW), .FWD_EN(FW), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .br_taken(br_taken),
        .pc_en(pc_en), .if2id_en(if2id_en), .if2id_flush(if2id_flush),
        .id2ex_en(id2ex_en), .id2ex_flush(id2ex_flush), .ex2mem_en(ex2mem_en),
        .mem2wb_en(mem2wb_en), .mem2wb_bubble(mem2wb_bubble), .mem_busy(mem_busy),
        .stall_cnt(stall_cnt)
      );
      assign ctrl[gi]   = {pc_en, if2id_en, if2id_flush, id2ex_en, id2ex_flush,
                           ex2mem_en, mem2wb_en, mem2wb_bubble, mem_busy};
      assign sc_dut[gi] = 16'(stall_cnt);
    end
  endgenerate

  // ---------------- reference model ----------------
  function automatic int mw_of(int i);
    case (i)
      0: return 3;
      1: return 0;
      2: return 1;
      3: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [15:0] cmax(int i);
    return (i == 4) ? 16'd3 : 16'hFFFF;
  endfunction

  function automatic bit m_match(logic [4:0] d);
    return (d != 5'd0) && ((d == id_src1) || (id_two_src && (d == id_src2)));
  endfunction

  function automatic bit m_hazard(int i);
    if (i == 4) return (ex_wb_en && m_match(ex_dest)) || (mem_wb_en && m_match(mem_dest));
    return ex_mem_r_en && ex_wb_en && m_match(ex_dest);
  endfunction

  function automatic bit m_freeze(int i);
    return !rst && ((forced[i] > 0) ||
                    (!skip[i] && (mem_r_en || mem_w_en) && (mw_of(i) > 0)));
  endfunction

  function automatic logic [8:0] m_ctrl(int i);
    if (rst)         return NORMAL;
    if (m_freeze(i)) return FREEZE;
    if (m_hazard(i)) return HAZARD;
    if (br_taken)    return BRANCH;
    return NORMAL;
  endfunction

  task automatic model_tick();
    bit fz, hz;
    for (int i = 0; i < 5; i++) begin
      fz = m_freeze(i);
      hz = m_hazard(i);
      if (rst) begin
        forced[i] = 0;
        skip[i]   = 1'b0;
        scnt[i]   = 16'd0;
      end else begin
        if ((fz || hz) && (scnt[i] != cmax(i))) scnt[i] = scnt[i] + 16'd1;
        if (forced[i] > 0) begin
          forced[i] = forced[i] - 1;
          if (forced[i] == 0) skip[i] = 1'b1;
        end else if (skip[i]) begin
          skip[i] = 1'b0;
        end else if ((mem_r_en || mem_w_en) && (mw_of(i) > 0)) begin
          forced[i] = mw_of(i) - 1;
          skip[i]   = (mw_of(i) == 1);
        end
      end
    end
  endtask

  // One clock: advance the model on the edge, then give inputs time to settle.
  task automatic cyc();
    @(posedge clk);
    model_tick();
    cyc_no++;
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; id_src1 = 5'd0; id_src2 = 5'd0; id_two_src = 1'b0;
    ex_dest = 5'd0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0;
    mem_dest = 5'd0; mem_wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic set_load_use(logic [4:0] d, logic [4:0] s1);
    ex_mem_r_en = 1'b1; ex_wb_en = 1'b1; ex_dest = d; id_src1 = s1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    mem_r_en = 1'b1;
    set_load_use(5'd5, 5'd5);
    cyc(); cyc();
    #3;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (ctrl[i] !== NORMAL || sc_dut[i] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset inst%0d: ctrl=%b cnt=%0d, required ctrl=%b cnt=0", i, ctrl[i], sc_dut[i], NORMAL);
      end
    end
    cyc();
    set_idle();
    #3;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (ctrl[i] !== m_ctrl(i) || sc_dut[i] !== scnt[i]) begin
        n_fail++;
        $display("FAIL reset_idle inst%0d: ctrl=%b cnt=%0d, required ctrl=%b cnt=%0d", i, ctrl[i], sc_dut[i], m_ctrl(i), scnt[i]);
      end
    end
    cyc();
  endtask

  task automatic test_load_use();
    set_idle();
    set_load_use(5'd5, 5'd5);
    #3;
    n_tests++;
    if (ctrl[0] !== HAZARD) begin
      n_fail++;
      $display("FAIL load_use ctrl: got %b, required %b", ctrl[0], HAZARD);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (ctrl[i] !== m_ctrl(i) || sc_dut[i] !== scnt[i]) begin
        n_fail++;
        $display("FAIL load_use inst%0d: ctrl=%b cnt=%0d, required ctrl=%b cnt=%0d", i, ctrl[i], sc_dut[i], m_ctrl(i), scnt[i]);
      end
    end
    cyc();
    set_idle();
    #3;
    n_tests++;
    if (sc_dut[0] !== 16'd1 || ctrl[0] !== NORMAL) begin
      n_fail++;
      $display("FAIL load_use after: ctrl=%b cnt=%0d, required ctrl=%b cnt=1", ctrl[0], sc_dut[0], NORMAL);
    end
    cyc();
  endtask

  task automatic test_zero_reg();
    for (int k = 0; k < 3; k++) begin
      set_idle();
      case (k)
        0: set_load_use(5'd0, 5'd0);
        1: begin set_load_use(5'd5, 5'd3); id_src2 = 5'd5; id_two_src = 1'b0; end
        default: begin set_load_use(5'd5, 5'd3); id_src2 = 5'd5; id_two_src = 1'b1; end
      endcase
      #3;
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (ctrl[i] !== m_ctrl(i) || sc_dut[i] !== scnt[i]) begin
          n_fail++;
          $display("FAIL zero_reg case%0d inst%0d: ctrl=%b cnt=%0d, required ctrl=%b cnt=%0d", k, i, ctrl[i], sc_dut[i], m_ctrl(i), scnt[i]);
        end
      end
      n_tests++;
      if (ctrl[0] !== ((k == 2) ? HAZARD : NORMAL)) begin
        n_fail++;
        $display("FAIL zero_reg direct case%0d: got %b, required %b", k, ctrl[0], (k == 2) ? HAZARD : NORMAL);
      end
      cyc();
    end
  endtask

  task automatic test_mem_freeze();
    int busy [5];
    set_idle();
    cyc(); cyc(); cyc(); cyc(); cyc();
    for (int i = 0; i < 5; i++) busy[i] = 0;
    mem_r_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #3;
      for (int i = 0; i < 5; i++) begin
        if (ctrl[i][0] === 1'b1) busy[i]++;
        n_tests++;
        if (ctrl[i] !== m_ctrl(i) || sc_dut[i] !== scnt[i]) begin
          n_fail++;
          $display("FAIL mem_freeze c%0d inst%0d: ctrl=%b cnt=%0d, required ctrl=%b cnt=%0d", c, i, ctrl[i], sc_dut[i], m_ctrl(i), scnt[i]);
        end
      end
      cyc();
    end
    n_tests++;
    if (busy[0] != 6 || busy[1] != 0 || busy[2] != 4) begin
      n_fail++;
      $display("FAIL mem_freeze busy_count: mw3=%0d mw0=%0d mw1=%0d, required 6 0 4", busy[0], busy[1], busy[2]);
    end
    set_idle();
    cyc(); cyc(); cyc(); cyc(); cyc();
  endtask

  task automatic test_priority();
    set_idle();
    mem_w_en = 1'b1;
    br_taken = 1'b1;
    set_load_use(5'd7, 5'd7);
    #3;
    n_tests++;
    if (ctrl[0] !== FREEZE) begin
      n_fail++;
      $display("FAIL priority freeze: got %b, required %b", ctrl[0], FREEZE);
    end
    cyc();
    mem_w_en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #3;
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (ctrl[i] !== m_ctrl(i) || sc_dut[i] !== scnt[i]) begin
          n_fail++;
          $display("FAIL priority c%0d inst%0d: ctrl=%b cnt=%0d, required ctrl=%b cnt=%0d", c, i, ctrl[i], sc_dut[i], m_ctrl(i), scnt[i]);
        end
      end
      cyc();
    end
    #3;
    n_tests++;
    if (ctrl[0] !== HAZARD) begin
      n_fail++;
      $display("FAIL priority hazard_over_branch: got %b, required %b", ctrl[0], HAZARD);
    end
    cyc();
    set_idle();
    br_taken = 1'b1;
    #3;
    n_tests++;
    if (ctrl[0] !== BRANCH) begin
      n_fail++;
      $display("FAIL priority branch: got %b, required %b", ctrl[0], BRANCH);
    end
    cyc();
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    cyc(); cyc(); cyc(); cyc(); cyc();
    mem_r_en = 1'b1;
    cyc();
    rst = 1'b1;
    #3;
    n_tests++;
    if (ctrl[3] !== NORMAL) begin
      n_fail++;
      $display("FAIL reset_mid_wait during: got %b, required %b", ctrl[3], NORMAL);
    end
    cyc();
    set_idle();
    #3;
    n_tests++;
    if (ctrl[3][0] !== 1'b0 || sc_dut[3] !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wait after: busy=%b cnt=%0d, required busy=0 cnt=0", ctrl[3][0], sc_dut[3]);
    end
    cyc();
  endtask

  task automatic test_saturate();
    set_idle();
    rst = 1'b1;
    cyc();
    set_idle();
    set_load_use(5'd9, 5'd9);
    for (int c = 0; c < 5; c++) cyc();
    set_idle();
    #3;
    n_tests++;
    if (sc_dut[4] !== 16'd3 || sc_dut[0] !== 16'd5) begin
      n_fail++;
      $display("FAIL saturate: cnt_w2=%0d cnt_w16=%0d, required 3 and 5", sc_dut[4], sc_dut[0]);
    end
    cyc();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 59) == 0);
      id_src1     = 5'($urandom_range(0, 3));
      id_src2     = 5'($urandom_range(0, 3));
      id_two_src  = 1'($urandom_range(0, 1));
      ex_dest     = 5'($urandom_range(0, 3));
      ex_wb_en    = 1'($urandom_range(0, 1));
      ex_mem_r_en = 1'($urandom_range(0, 1));
      mem_dest    = 5'($urandom_range(0, 3));
      mem_wb_en   = 1'($urandom_range(0, 1));
      mem_r_en    = ($urandom_range(0, 3) == 0);
      mem_w_en    = ($urandom_range(0, 5) == 0);
      br_taken    = 1'($urandom_range(0, 1));
      #3;
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (ctrl[i] !== m_ctrl(i) || sc_dut[i] !== scnt[i]) begin
          n_fail++;
          $display("FAIL random c%0d inst%0d: ctrl=%b cnt=%0d, required ctrl=%b cnt=%0d", c, i, ctrl[i], sc_dut[i], m_ctrl(i), scnt[i]);
        end
      end
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      forced[i] = 0;
      skip[i]   = 1'b0;
      scnt[i]   = 16'd0;
    end
    set_idle();
    #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mem_freeze();
    test_priority();
    test_reset_mid_wait();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers (IF2ID, ID2EX, EXE2MEM, MEM2WB).
- Generates per-stage enable and flush controls for three cases: load-use hazards, taken-branch flushes, and multi-cycle data-memory waits.
- Contains a small FSM and down-counter that freeze the whole pipeline while a memory access completes.
- Contains a saturating stall-cycle counter for performance checks.

Parameters:
- MEM_WAIT, 2: total freeze cycles per data-memory access. Legal range 0..15; 0 means single-cycle memory and no freeze.
- FWD_EN, 1: 1 means a forwarding unit exists, so only load-use is checked. 0 means any EX or MEM writer matching an ID source stalls.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- id_src1  in  5  ID-stage source register 1.
- id_src2  in  5  ID-stage source register 2.
- id_two_src  in  1  ID instruction reads id_src2.
- ex_dest  in  5  ID2EX dest.
- ex_wb_en  in  1  ID2EX write-back enable.
- ex_mem_r_en  in  1  ID2EX load flag.
- mem_dest  in  5  EXE2MEM dest.
- mem_wb_en  in  1  EXE2MEM write-back enable.
- mem_r_en  in  1  EXE2MEM load flag.
- mem_w_en  in  1  EXE2MEM store flag.
- br_taken  in  1  branch taken, resolved in ID.
- pc_en  out  1  PC update enable.
- if2id_en  out  1  IF2ID load enable.
- if2id_flush  out  1  IF2ID clear.
- id2ex_en  out  1  ID2EX load enable.
- id2ex_flush  out  1  ID2EX bubble insert.
- ex2mem_en  out  1  EXE2MEM load enable.
- mem2wb_en  out  1  MEM2WB load enable.
- mem2wb_bubble  out  1  force MEM2WB WB_EN/MEM_R_EN to 0.
- mem_busy  out  1  freeze active.
- stall_cnt  out  CNT_W  saturating count of stall and freeze cycles.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Registered state: state {RUN, WAIT, DONE}, cnt[3:0], stall_cnt. All outputs except stall_cnt are combinational from state, cnt and inputs.
- Reset: state=RUN, cnt=0, stall_cnt=0.
  - While rst=1, force all *_en=1, all flushes=0, mem2wb_bubble=0, mem_busy=0.
  - Reset in WAIT or DONE returns to RUN on the next edge with no further freeze.
- Memory access: acc = mem_r_en | mem_w_en.
- freeze is high when either:
  - state=RUN and acc and MEM_WAIT>0, or
  - state=WAIT.
- FSM transitions:
  - RUN, acc, MEM_WAIT>=2: go to WAIT, cnt=MEM_WAIT-2.
  - RUN, acc, MEM_WAIT=1: go to DONE.
  - RUN otherwise: stay in RUN.
  - WAIT: if cnt=0 go to DONE, else cnt-1.
  - DONE: always go to RUN, one cycle. freeze=0 and acc is ignored here, so the same instruction cannot retrigger.
- Result: exactly MEM_WAIT freeze cycles, followed by one advance cycle.
- hazard, when FWD_EN=1:
  - ex_mem_r_en & ex_wb_en & ex_dest!=0, and
  - ex_dest matches id_src1, or (id_two_src and ex_dest matches id_src2).
- hazard, when FWD_EN=0:
  - the same match against ex_dest when ex_wb_en, regardless of load, OR
  - the same match against mem_dest when mem_wb_en.
  - Register 0 never hazards.
- Output priority:
  1. freeze: all *_en=0, all flushes=0, mem2wb_bubble=1, mem_busy=1.
  2. else hazard: pc_en=0, if2id_en=0, id2ex_flush=1; all other enables=1; if2id_flush=0. br_taken is ignored because the branch operands are not yet valid.
  3. else br_taken: if2id_flush=1; all enables=1.
  4. else: all enables=1, flushes=0, mem2wb_bubble=0.
- stall_cnt: increments each cycle with freeze|hazard (rst=0); holds at all-ones.

Test Plan:
- Load-use: FWD_EN=1, ex_mem_r_en=1, ex_wb_en=1, ex_dest=5, id_src1=5 -> pc_en=0, if2id_en=0, id2ex_flush=1 for 1 cycle; stall_cnt 0->1.
- Zero register: the same stimulus with ex_dest=0 and id_src1=0 -> no stall; id_two_src=0 with id_src2=5 matching -> no stall.
- Memory freeze: MEM_WAIT=3, mem_r_en=1 held -> mem_busy=1 for exactly 3 cycles, then 1 cycle all enables=1, then RUN. Back-to-back loads give the pattern 3 frozen, 1 advance, 3 frozen.
- Priority: freeze, hazard and br_taken all high -> only the freeze pattern. Hazard and br_taken high -> stall, if2id_flush=0.
- MEM_WAIT=0 and 1: MEM_WAIT=0 with acc -> never busy. MEM_WAIT=1 -> busy 1 cycle, DONE 1 cycle.
- Reset mid-WAIT: MEM_WAIT=4, assert rst in the 2nd freeze cycle -> next cycle RUN, mem_busy=0, stall_cnt=0. CNT_W=2 with 5 stall cycles -> stall_cnt=3.
